// File: rtl/sgd_pkg.sv
// Shared types and field layout for the SGD server-side TX broadcast scheduler.
// Metadata is {len, session}; status carries session in [15:0] and error code in [17:16].
package sgd_pkg;

  localparam int META_W        = 32;
  localparam int STS_W         = 64;
  localparam int SESS_W        = 16;
  localparam int LEN_W         = 16;
  localparam int ERR_W         = 2;
  localparam int META_SESS_LSB = 0;
  localparam int META_LEN_LSB  = 16;
  localparam int STS_SESS_LSB  = 0;
  localparam int STS_ERR_LSB   = 16;

  typedef enum logic [ERR_W-1:0] {
    STS_OK    = 2'd0,
    STS_ERR_1 = 2'd1,
    STS_ERR_2 = 2'd2,
    STS_ERR_3 = 2'd3
  } sts_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_META,
    ST_DATA,
    ST_WAIT_STS,
    ST_DONE
  } state_e;

  function automatic logic [META_W-1:0] pack_meta(input logic [LEN_W-1:0]  len,
                                                  input logic [SESS_W-1:0] sess);
    return {len, sess};
  endfunction

endpackage

// File: rtl/sgd_lowest_set.sv
// Combinational priority encoder: index of the lowest set bit of vec, plus a found flag.
module sgd_lowest_set #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgd_tx_bcast_sched.sv
// Sends one 512-bit line to every enabled worker session in turn, retrying on
// error status or timeout, and reports the workers that exhausted their retries.
module sgd_tx_bcast_sched
  import sgd_pkg::*;
#(
  parameter int WORKER_NUM     = 4,
  parameter int PKT_BYTES      = 64,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [16*WORKER_NUM-1:0] session_id,
  input  logic [WORKER_NUM-1:0]    worker_en,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [511:0]             req_data,
  output logic                     meta_valid,
  input  logic                     meta_ready,
  output logic [META_W-1:0]        meta_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [511:0]             tx_data,
  output logic [63:0]              tx_keep,
  output logic                     tx_last,
  input  logic                     sts_valid,
  output logic                     sts_ready,
  input  logic [STS_W-1:0]         sts_data,
  output logic                     busy,
  output logic                     done,
  output logic [WORKER_NUM-1:0]    fail_mask,
  output logic [15:0]              stray_cnt
);

  localparam int IW = (WORKER_NUM > 1) ? $clog2(WORKER_NUM) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e                r_state;
  logic [511:0]          r_payload;
  logic [WORKER_NUM-1:0] r_pending;
  logic [WORKER_NUM-1:0] r_fail_mask;
  logic [IW-1:0]         r_idx;
  logic [SESS_W-1:0]     r_session;
  logic [RW-1:0]         r_retry;
  logic [TW-1:0]         r_timer;
  logic [15:0]           r_stray;

  logic [IW-1:0]         w_idx;
  logic                  w_found;
  logic [SESS_W-1:0]     w_sel_session;
  logic [SESS_W-1:0]     w_sts_sess;
  sts_err_e              w_sts_err;
  logic                  w_match;
  logic                  w_stray;
  logic                  w_timeout;
  logic                  w_fail;
  logic [WORKER_NUM-1:0] w_bit;
  logic                  w_unused;

  sgd_lowest_set #(
    .N  (WORKER_NUM),
    .IW (IW)
  ) u_lowest_set (
    .vec   (r_pending),
    .idx   (w_idx),
    .found (w_found)
  );

  always_comb begin
    w_sel_session = '0;
    for (int unsigned i = 0; i < WORKER_NUM; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_session = session_id[i*16 +: 16];
      end
    end
  end

  assign w_sts_sess = sts_data[STS_SESS_LSB +: SESS_W];
  assign w_sts_err  = sts_err_e'(sts_data[STS_ERR_LSB +: ERR_W]);
  assign w_unused   = ^sts_data[STS_W-1:STS_ERR_LSB+ERR_W];

  // A matching status beat wins over a timeout landing in the same cycle.
  assign w_match   = sts_valid && (r_state == ST_WAIT_STS) && (w_sts_sess == r_session);
  assign w_stray   = sts_valid && !w_match;
  assign w_timeout = (r_state == ST_WAIT_STS) && !w_match && (r_timer == '0);
  assign w_fail    = (w_match && (w_sts_err != STS_OK)) || w_timeout;
  assign w_bit     = WORKER_NUM'(1) << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_payload   <= '0;
      r_pending   <= '0;
      r_fail_mask <= '0;
      r_idx       <= '0;
      r_session   <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_stray     <= '0;
    end else begin
      if (w_stray && (r_stray != '1)) begin
        r_stray <= r_stray + 16'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_payload   <= req_data;
            r_pending   <= worker_en;
            r_fail_mask <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_idx     <= w_idx;
            r_session <= w_sel_session;
            r_state   <= ST_META;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_META: begin
          if (meta_ready) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            r_timer <= TW'(TIMEOUT_CYCLES - 1);
            r_state <= ST_WAIT_STS;
          end
        end
        ST_WAIT_STS: begin
          if (w_match && (w_sts_err == STS_OK)) begin
            r_pending <= r_pending & ~w_bit;
            r_retry   <= '0;
            r_state   <= ST_SELECT;
          end else if (w_fail) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + RW'(1);
              r_state <= ST_META;
            end else begin
              r_fail_mask <= r_fail_mask | w_bit;
              r_pending   <= r_pending & ~w_bit;
              r_retry     <= '0;
              r_state     <= ST_SELECT;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign meta_valid = (r_state == ST_META);
  assign meta_data  = pack_meta(LEN_W'(PKT_BYTES), r_session);
  assign tx_valid   = (r_state == ST_DATA);
  assign tx_last    = tx_valid;
  assign tx_data    = r_payload;
  assign tx_keep    = '1;
  assign sts_ready  = 1'b1;
  assign fail_mask  = r_fail_mask;
  assign stray_cnt  = r_stray;

endmodule
